sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's 1-bit/32-deep FIFO.
- Adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks inside the tt_um top level, single clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, 2..256
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on data_out while !empty

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
data_in  in  WIDTH  write data
write_en  in  1  write request
read_en  in  1  read request
flush  in  1  synchronous clear of contents (pointers/count), flags not errors
clear_err  in  1  clears sticky overflow/underflow
data_out  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  clog2(DEPTH)+1  current occupancy 0..DEPTH
overflow  out  1  sticky: write_en while full
underflow  out  1  sticky: read_en while empty

Behaviour:
- Reset (reset==0 at clk edge):
  - pointers = 0, count = 0, data_out = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (assuming AF_LEVEL > 0)
  - overflow = underflow = 0
  - Memory contents are not cleared. Reset overrides all other inputs.
- Pointers are clog2(DEPTH)+1 bits with a wrap bit.
  - full: low bits equal and wrap bits differ.
  - empty: pointers equal.
  - Increment wraps modulo 2*DEPTH.
- Write accepted iff write_en && !full: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff read_en && !empty: rd_ptr++.
- Flags and count are registered and reflect state after the current edge; there are no combinational paths from inputs to flags.
- count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous read+write:
  - Not full, not empty: both accepted, count holds.
  - Empty: only the write is accepted, underflow sets.
  - Full: only the read is accepted, overflow sets. The freed slot is not reused in the same cycle.
- Read timing:
  - FWFT=0: data_out <= mem[rd_ptr] on an accepted read, valid the cycle after. Otherwise data_out holds its last value.
  - FWFT=1: data_out = mem[rd_ptr] whenever !empty, and shows the last popped word (held) when empty. read_en pops the head.
  - Write-to-first-read latency: write at edge N, empty=0 after N, read accepted at N+1. Data is visible after N+1 (FWFT=0) or after N (FWFT=1).
- flush=1 (with reset high):
  - pointers and count go to 0, empty=1, full=0.
  - Any same-cycle read/write is ignored.
  - Error flags are kept.
- Error flags:
  - overflow <= 1 when write_en && full.
  - underflow <= 1 when read_en && empty.
  - clear_err clears both; a set event in the same cycle wins over clear.

Decomposition:
- Package fifo_pkg:
  - clog2 helper function
  - pointer-width and count-width localparams derived from DEPTH
  - parameter-legality checks (DEPTH power of two, AE_LEVEL < AF_LEVEL <= DEPTH)
- One sub-module, fifo_ram:
  - WIDTH x DEPTH, one write port, one read port
  - synchronous read for FWFT=0, asynchronous read for FWFT=1
- Pointer/flag logic stays in sync_fifo_flags.

Test Plan:
- Reset: hold reset=0 two cycles with write_en=1 -> count=0, empty=1, full=0, almost_empty=1, data_out=0, no write stored.
- Fill/drain (FWFT=0): write 0x01..0x10 (16 words) -> full=1 after 16th edge, almost_full from count=14. Read 16 -> data_out 0x01..0x10 in order, one cycle after each read, empty=1 at end.
- Errors: at full, write 0xAA -> overflow=1, count stays 16, 0xAA never read back. At empty, read -> underflow=1. clear_err -> both 0.
- Simultaneous: count=5, write_en=read_en=1 for 20 cycles -> count stays 5, pointers wrap past 16 without a false full/empty, data order preserved.
- FWFT=1: write 0x3C into empty FIFO -> data_out=0x3C the following cycle with no read_en. Read -> empty=1.
- Flush/reset mid-operation: count=9, flush=1 with write_en=1 -> count=0, empty=1, overflow unchanged. Repeat with reset=0 mid-burst -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, sizing helpers and parameter-legality checks for sync_fifo_flags.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Which of the two requests were accepted this cycle: {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Count must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int af_level, input int ae_level,
                                   input int fwft);
    return (width >= 1) && is_pow2(depth) && (depth >= 2) && (depth <= 256) &&
           (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer-facing bundle of the FIFO: write side, read side, flags and errors.
interface sync_fifo_flags_if #(
  parameter int WIDTH = fifo_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = fifo_pkg::DEFAULT_DEPTH
);
  localparam int CNT_W = fifo_pkg::count_width(DEPTH);

  logic [WIDTH-1:0] data_in;
  logic             write_en;
  logic             read_en;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  // The block that drives requests into the FIFO.
  modport master (
    output data_in, write_en, read_en, flush, clear_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  data_in, write_en, read_en, flush, clear_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage with one write port and one read port; the read port is
// registered (SYNC_READ=1) or combinational (SYNC_READ=0, used for first-word-fall-through).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int SYNC_READ = 1,
  parameter int ADDR_W    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (SYNC_READ != 0) begin : g_sync_read
    logic [WIDTH-1:0] rd_q;

    // Registered read: the word at rd_addr appears the cycle after rd_en.
    always_ff @(posedge clk) begin
      if (rd_en) rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;
  end else begin : g_async_read
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    assign rd_data      = mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through output.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_flags_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_W  = count_width(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
    $error("sync_fifo_flags: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_r, count_nxt;
  logic             full_r, empty_r, af_r, ae_r;
  logic             full_nxt, empty_nxt, af_nxt, ae_nxt;
  logic             ovf_r, udf_r, ovf_nxt, udf_nxt;
  logic             read_seen;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;
  fifo_op_e         op;

  // Flush suppresses both requests; full/empty gate them otherwise.
  assign wr_acc = bus.write_en && !full_r  && !bus.flush;
  assign rd_acc = bus.read_en  && !empty_r && !bus.flush;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  // Next pointers, count and the flags derived from them, so flags register post-edge state.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_r;
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      unique case (op)
        OP_WRITE: begin
          wr_ptr_nxt = wr_ptr + 1'b1;
          count_nxt  = count_r + 1'b1;
        end
        OP_READ: begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          count_nxt  = count_r - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr_nxt = wr_ptr + 1'b1;
          rd_ptr_nxt = rd_ptr + 1'b1;
        end
        OP_IDLE: ;
      endcase
    end
    full_nxt  = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    af_nxt    = (count_nxt >= AF_CNT);
    ae_nxt    = (count_nxt <= AE_CNT);
  end

  // Sticky errors: a set event in the same cycle beats clear_err; flush leaves them alone.
  always_comb begin
    ovf_nxt = ovf_r;
    udf_nxt = udf_r;
    if (bus.write_en && full_r)     ovf_nxt = 1'b1;
    else if (bus.clear_err)         ovf_nxt = 1'b0;
    if (bus.read_en && empty_r)     udf_nxt = 1'b1;
    else if (bus.clear_err)         udf_nxt = 1'b0;
  end

  // Control state register; read_seen forces data_out to zero until the first pop after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      af_r      <= 1'b0;
      ae_r      <= 1'b1;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
      read_seen <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count_r   <= count_nxt;
      full_r    <= full_nxt;
      empty_r   <= empty_nxt;
      af_r      <= af_nxt;
      ae_r      <= ae_nxt;
      ovf_r     <= ovf_nxt;
      udf_r     <= udf_nxt;
      read_seen <= read_seen || rd_acc;
    end
  end

  fifo_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .SYNC_READ ((FWFT == 0) ? 1 : 0),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  if (FWFT == 0) begin : g_registered_out
    assign bus.data_out = read_seen ? ram_rdata : '0;
  end else begin : g_fwft_out
    logic [WIDTH-1:0] hold;

    // Capture the word being popped so it stays visible once the FIFO runs empty.
    always_ff @(posedge clk) begin
      if (rd_acc) hold <= ram_rdata;
    end

    assign bus.data_out = !empty_r ? ram_rdata : (read_seen ? hold : '0);
  end

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one registered-read and one FWFT instance share the stimulus;
// a queue-based model is compared every cycle, with hand-computed checks along the way.
module tb_sync_fifo_flags;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 14;
  localparam int AE_LEVEL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       we, re, fl, ce;
  logic       check_en = 1'b0;

  int errors = 0;
  int checks = 0;

  sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus0.data_in   = din;
  assign bus0.write_en  = we;
  assign bus0.read_en   = re;
  assign bus0.flush     = fl;
  assign bus0.clear_err = ce;
  assign bus1.data_in   = din;
  assign bus1.write_en  = we;
  assign bus1.read_en   = re;
  assign bus1.flush     = fl;
  assign bus1.clear_err = ce;

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, outputs derived from occupancy.
  logic [7:0] mq[$];
  logic       ovf_m = 1'b0, udf_m = 1'b0;
  logic [7:0] dout0_m = 8'h00, hold1_m = 8'h00;

  always @(posedge clk) begin
    int sz;
    sz = mq.size();
    if (!reset) begin
      mq.delete();
      ovf_m   = 1'b0;
      udf_m   = 1'b0;
      dout0_m = 8'h00;
      hold1_m = 8'h00;
    end else begin
      if (we && sz == DEPTH) ovf_m = 1'b1;
      else if (ce)           ovf_m = 1'b0;
      if (re && sz == 0)     udf_m = 1'b1;
      else if (ce)           udf_m = 1'b0;
      if (fl) begin
        mq.delete();
      end else begin
        if (re && sz != 0) begin
          dout0_m = mq.pop_front();
          hold1_m = dout0_m;
        end
        if (we && sz != DEPTH) mq.push_back(din);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int sz;
    logic [7:0] exp1;
    if (check_en) begin
      sz   = mq.size();
      exp1 = (sz != 0) ? mq[0] : hold1_m;
      check("m.count0",  32'(bus0.count),        sz);
      check("m.full0",   32'(bus0.full),         32'(sz == DEPTH));
      check("m.empty0",  32'(bus0.empty),        32'(sz == 0));
      check("m.af0",     32'(bus0.almost_full),  32'(sz >= AF_LEVEL));
      check("m.ae0",     32'(bus0.almost_empty), 32'(sz <= AE_LEVEL));
      check("m.ovf0",    32'(bus0.overflow),     32'(ovf_m));
      check("m.udf0",    32'(bus0.underflow),    32'(udf_m));
      check("m.dout0",   32'(bus0.data_out),     32'(dout0_m));
      check("m.count1",  32'(bus1.count),        sz);
      check("m.full1",   32'(bus1.full),         32'(sz == DEPTH));
      check("m.empty1",  32'(bus1.empty),        32'(sz == 0));
      check("m.ovf1",    32'(bus1.overflow),     32'(ovf_m));
      check("m.udf1",    32'(bus1.underflow),    32'(udf_m));
      check("m.dout1",   32'(bus1.data_out),     32'(exp1));
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic f = 1'b0, input logic c = 1'b0, input logic rs = 1'b1);
    we = w; re = r; din = d; fl = f; ce = c; reset = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; we = 1'b1; re = 1'b0; din = 8'h55; fl = 1'b0; ce = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    cyc(1, 0, 8'h55, 0, 0, 0);
    check("rst.count", 32'(bus0.count), 0);
    check("rst.empty", 32'(bus0.empty), 1);
    check("rst.full",  32'(bus0.full), 0);
    check("rst.ae",    32'(bus0.almost_empty), 1);
    check("rst.af",    32'(bus0.almost_full), 0);
    check("rst.dout0", 32'(bus0.data_out), 0);
    check("rst.dout1", 32'(bus1.data_out), 0);

    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 8'(i));
      if (i == 1) begin
        check("fill.fwft_head", 32'(bus1.data_out), 32'h01);
        check("fill.reg_idle",  32'(bus0.data_out), 32'h00);
      end
      if (i == 2)  check("fill.ae_at2", 32'(bus0.almost_empty), 1);
      if (i == 3)  check("fill.ae_at3", 32'(bus0.almost_empty), 0);
      if (i == 13) check("fill.af_at13", 32'(bus0.almost_full), 0);
      if (i == 14) check("fill.af_at14", 32'(bus0.almost_full), 1);
      if (i == 15) check("fill.full_at15", 32'(bus0.full), 0);
    end
    check("fill.full",  32'(bus0.full), 1);
    check("fill.count", 32'(bus0.count), 16);

    cyc(1, 0, 8'hAA);
    check("ovf.flag",  32'(bus0.overflow), 1);
    check("ovf.count", 32'(bus0.count), 16);

    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 8'h00);
      check("drain.data", 32'(bus0.data_out), 32'(i));
    end
    check("drain.empty", 32'(bus0.empty), 1);

    cyc(0, 1, 8'h00);
    check("udf.flag",     32'(bus0.underflow), 1);
    check("udf.ovf_kept", 32'(bus0.overflow), 1);
    cyc(0, 0, 8'h00, 0, 1);
    check("clr.ovf", 32'(bus0.overflow), 0);
    check("clr.udf", 32'(bus0.underflow), 0);

    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 8'(8'h25 + i));
      check("simul.count", 32'(bus0.count), 5);
    end
    check("simul.last_pop", 32'(bus0.data_out), 32'h33);
    check("simul.head",     32'(bus1.data_out), 32'h34);

    for (int i = 0; i < 11; i++) cyc(1, 0, 8'(8'h40 + i));
    check("full2.full", 32'(bus0.full), 1);
    cyc(1, 1, 8'hBB);
    check("fullrw.count", 32'(bus0.count), 15);
    check("fullrw.ovf",   32'(bus0.overflow), 1);
    check("fullrw.data",  32'(bus0.data_out), 32'h34);

    for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00);
    check("drain2.empty", 32'(bus0.empty), 1);
    cyc(1, 1, 8'hCC);
    check("emptyrw.count", 32'(bus0.count), 1);
    check("emptyrw.udf",   32'(bus0.underflow), 1);
    check("emptyrw.head",  32'(bus1.data_out), 32'hCC);
    cyc(0, 1, 8'h00);
    check("emptyrw.pop", 32'(bus0.data_out), 32'hCC);

    cyc(1, 0, 8'h3C);
    check("fwft.head",  32'(bus1.data_out), 32'h3C);
    check("fwft.empty", 32'(bus1.empty), 0);
    cyc(0, 1, 8'h00);
    check("fwft.empty_after", 32'(bus1.empty), 1);
    check("fwft.held",        32'(bus1.data_out), 32'h3C);
    check("fwft.reg_data",    32'(bus0.data_out), 32'h3C);

    for (int i = 0; i < 9; i++) cyc(1, 0, 8'(8'h50 + i));
    check("flush.pre_count", 32'(bus0.count), 9);
    cyc(1, 0, 8'h77, 1);
    check("flush.count", 32'(bus0.count), 0);
    check("flush.empty", 32'(bus0.empty), 1);
    check("flush.ovf",   32'(bus0.overflow), 1);
    check("flush.udf",   32'(bus0.underflow), 1);
    check("flush.held",  32'(bus1.data_out), 32'h3C);
    cyc(1, 0, 8'h61);
    cyc(0, 1, 8'h00);
    check("flush.next_data", 32'(bus0.data_out), 32'h61);

    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h70 + i));
    cyc(1, 0, 8'h74, 0, 0, 0);
    check("mrst.count", 32'(bus0.count), 0);
    check("mrst.empty", 32'(bus0.empty), 1);
    check("mrst.ae",    32'(bus0.almost_empty), 1);
    check("mrst.ovf",   32'(bus0.overflow), 0);
    check("mrst.udf",   32'(bus0.underflow), 0);
    check("mrst.dout0", 32'(bus0.data_out), 0);
    check("mrst.dout1", 32'(bus1.data_out), 0);
    cyc(1, 0, 8'h99);
    cyc(0, 1, 8'h00);
    check("mrst.after", 32'(bus0.data_out), 32'h99);
    cyc(0, 0, 8'h00);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
